life_manager: RTL and testbench
===============================

Name: life_manager

Overview:
- Parametrised lives and game-over controller for the player ship. It merges NUM_HIT_SRC rocket-hit lines, an alien-collision pulse and the aliens-reached-border flag.
- Maintains a saturating life counter and a post-hit invulnerability window. Supports extra-life awards and god mode.
- Drives a sticky registered `lost` flag consumed by the game-state controller, plus a `lives` count for the HUD digit renderer.

Parameters:
- NUM_HIT_SRC, 3, number of independent rocket-hit lines (one per alien rocket object), >=1
- INIT_LIVES, 3, lives loaded on reset and on newGame, 1..MAX_LIVES
- MAX_LIVES, 7, saturation ceiling for extra-life awards
- LIFE_W, 3, width of the lives output; MAX_LIVES < 2**LIFE_W required
- INVULN_CYCLES, 50000000, clock cycles of invulnerability after a life is lost (1 s at 50 MHz), >=1

Ports:
- clk, in, 1, system clock
- resetN, in, 1, reset; one clock; reset is synchronous and active-low
- newGame, in, 1, synchronous restart pulse; same effect as reset
- playerHitByRocket, in, NUM_HIT_SRC, level per rocket; high while that rocket overlaps the player
- playerHitByAlienPulse, in, 1, one-cycle alien/player collision pulse
- aliensReachedBorder, in, 1, level; alien formation has reached the player row
- extraLifePulse, in, 1, one-cycle extra-life award
- GodMode, in, 1, level; suppresses rocket and alien-collision damage
- lives, out, LIFE_W, current life count
- invulnerable, out, 1, high while in the INVULN state
- lifeLostPulse, out, 1, one-cycle pulse in the cycle after a life is decremented (sound/flash trigger)
- lost, out, 1, registered, sticky game-over flag

Behaviour:
- **Reset or newGame** (resetN=0 or newGame=1 at a clk edge):
  - state=ALIVE, lives=INIT_LIVES, invuln counter=0.
  - lost=0, invulnerable=0, lifeLostPulse=0.
  - Per-bit edge-history register is set to the current playerHitByRocket value, so a rocket already overlapping the player does not register a hit.
  - resetN has priority over newGame.
- **Edge detection:**
  - Per bit i: rise[i] = playerHitByRocket[i] & ~hist[i]; hist updates every cycle in every state.
  - rocketHit = |rise. Any number of simultaneous rising edges counts as ONE hit.
- **Damage event:** dmg = (rocketHit | playerHitByAlienPulse) & ~GodMode.
- **State ALIVE:**
  - If aliensReachedBorder=1 (GodMode ignored): go to DEAD; lives unchanged.
  - Else if dmg and lives==1:
    - lives to 0, go to DEAD.
    - extraLifePulse in the same cycle does NOT save the player; extra life is applied only when lives>1.
  - Else if dmg (lives>1):
    - If extraLifePulse is also high, lives is unchanged (net 0); otherwise lives-1.
    - Go to INVULN, counter loaded with INVULN_CYCLES-1.
    - lifeLostPulse=1 next cycle (also in the net-0 case).
  - Else if extraLifePulse: lives = min(lives+1, MAX_LIVES).
- **State INVULN:**
  - dmg is ignored.
  - aliensReachedBorder still goes to DEAD.
  - extraLifePulse is applied with saturation.
  - Counter decrements every cycle; at counter==0 the next state is ALIVE.
  - Total INVULN duration is exactly INVULN_CYCLES cycles.
- **State DEAD:**
  - lost=1 (registered; asserted the cycle after the entering event).
  - All inputs are ignored except reset/newGame.
  - lives frozen.
- **Outputs:**
  - invulnerable = (state==INVULN), registered.
  - lifeLostPulse is high for exactly one cycle per accepted damage event that does not kill. A fatal hit raises lost, not lifeLostPulse.
- **Latency:** every output changes one clk after the causing input sample; no combinational input-to-output path.
- **Width rules:**
  - Invuln counter width = $clog2(INVULN_CYCLES+1).
  - lives never underflows below 0 and never exceeds MAX_LIVES.
- **Reset mid-INVULN or DEAD:** returns to ALIVE with INIT_LIVES next cycle; the counter is cleared.

Test Plan:
- Reset, INIT_LIVES=3, INVULN_CYCLES=4 -> lives=3, lost=0. Single rocket bit0 rising -> lives=2, lifeLostPulse for 1 cycle, invulnerable high exactly 4 cycles.
- Bits 0 and 2 rise in the same cycle while ALIVE with lives=3 -> lives=2 (one hit only). A second rise during INVULN -> lives stays 2.
- lives=1, rocket rising edge -> lives=0, lost=1 next cycle and sticky. lifeLostPulse stays 0. Further extraLifePulse -> lives stays 0. newGame -> lives=3, lost=0.
- GodMode=1 with repeated rocket edges and an alien pulse -> lives=3, lost=0. aliensReachedBorder=1 -> lost=1 next cycle.
- lives=7 (MAX), extraLifePulse -> lives=7. Simultaneous dmg+extraLifePulse at lives=3 -> lives=3, INVULN entered, lifeLostPulse=1.
- Rocket bit held high across reset deassertion -> no hit counted. resetN=0 mid-INVULN -> ALIVE, lives=3, invulnerable=0 next cycle.

Source files
------------

// File: rtl/life_manager.sv
// ============================================================================
// Module   : life_manager
// Purpose  : Player lives counter, post-hit invulnerability and game-over flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module life_manager #(
  parameter int NUM_HIT_SRC   = 3,
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 7,
  parameter int LIFE_W        = 3,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   newGame,
  input  logic [NUM_HIT_SRC-1:0] playerHitByRocket,
  input  logic                   playerHitByAlienPulse,
  input  logic                   aliensReachedBorder,
  input  logic                   extraLifePulse,
  input  logic                   GodMode,
  output logic [LIFE_W-1:0]      lives,
  output logic                   invulnerable,
  output logic                   lifeLostPulse,
  output logic                   lost
);

  localparam int                c_CNT_W    = $clog2(INVULN_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(INVULN_CYCLES - 1);
  localparam logic [LIFE_W-1:0]  c_MAX      = LIFE_W'(MAX_LIVES);
  localparam logic [LIFE_W-1:0]  c_INIT     = LIFE_W'(INIT_LIVES);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t                   r_state, w_stateNext;
  logic [LIFE_W-1:0]        r_lives, w_livesNext, w_livesInc;
  logic [c_CNT_W-1:0]       r_cnt, w_cntNext;
  logic [NUM_HIT_SRC-1:0]   r_hist;
  logic                     r_inv, r_lost, r_pulse, w_pulseNext;
  logic                     w_rocketHit, w_dmg;

  // Simultaneous rising edges on several rocket lines collapse into one hit.
  assign w_rocketHit = |(playerHitByRocket & ~r_hist);
  assign w_dmg       = (w_rocketHit | playerHitByAlienPulse) & ~GodMode;
  assign w_livesInc  = (r_lives >= c_MAX) ? c_MAX : r_lives + LIFE_W'(1);

  always_comb begin
    w_stateNext = r_state;
    w_livesNext = r_lives;
    w_cntNext   = r_cnt;
    w_pulseNext = 1'b0;
    case (r_state)
      ALIVE: begin
        if (aliensReachedBorder) begin
          w_stateNext = DEAD;
        end else if (w_dmg && r_lives <= LIFE_W'(1)) begin
          // A same-cycle extra life cannot rescue the last life.
          w_livesNext = '0;
          w_stateNext = DEAD;
        end else if (w_dmg) begin
          if (!extraLifePulse) w_livesNext = r_lives - LIFE_W'(1);
          w_stateNext = INVULN;
          w_cntNext   = c_CNT_LOAD;
          w_pulseNext = 1'b1;
        end else if (extraLifePulse) begin
          w_livesNext = w_livesInc;
        end
      end
      INVULN: begin
        if (aliensReachedBorder) begin
          w_stateNext = DEAD;
          w_cntNext   = '0;
        end else begin
          if (extraLifePulse) w_livesNext = w_livesInc;
          if (r_cnt == '0) w_stateNext = ALIVE;
          else             w_cntNext   = r_cnt - c_CNT_W'(1);
        end
      end
      DEAD: begin
        w_stateNext = DEAD;
      end
      default: begin
        w_stateNext = ALIVE;
        w_cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_hist <= playerHitByRocket;
    if (!resetN || newGame) begin
      r_state <= ALIVE;
      r_lives <= c_INIT;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_lost  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_lives <= w_livesNext;
      r_cnt   <= w_cntNext;
      r_inv   <= (w_stateNext == INVULN);
      r_lost  <= (w_stateNext == DEAD);
      r_pulse <= w_pulseNext;
    end
  end

  assign lives         = r_lives;
  assign invulnerable  = r_inv;
  assign lifeLostPulse = r_pulse;
  assign lost          = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_life_manager.sv
// ============================================================================
// Module   : tb_life_manager
// Purpose  : Directed self-checking bench for life_manager.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_life_manager;

  logic       clk = 1'b0;
  logic       resetN, newGame, alienPulse, border, extra, god;
  logic [2:0] rocket;
  logic [2:0] lives;
  logic       invulnerable, lifeLostPulse, lost;

  int nVec = 0;
  int nErr = 0;

  life_manager #(
    .NUM_HIT_SRC(3), .INIT_LIVES(3), .MAX_LIVES(7), .LIFE_W(3), .INVULN_CYCLES(4)
  ) dut (
    .clk(clk), .resetN(resetN), .newGame(newGame),
    .playerHitByRocket(rocket), .playerHitByAlienPulse(alienPulse),
    .aliensReachedBorder(border), .extraLifePulse(extra), .GodMode(god),
    .lives(lives), .invulnerable(invulnerable),
    .lifeLostPulse(lifeLostPulse), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doNewGame();
    newGame = 1'b1;
    step();
    newGame = 1'b0;
  endtask

  initial begin
    int invCnt;
    int pulseCnt;
    resetN = 1'b0; newGame = 1'b0; rocket = '0; alienPulse = 1'b0;
    border = 1'b0; extra = 1'b0; god = 1'b0;
    step(2);
    resetN = 1'b1;
    chk("reset lives", lives, 3);
    chk("reset lost", lost, 0);
    chk("reset invuln", invulnerable, 0);
    chk("reset pulse", lifeLostPulse, 0);

    // single rocket hit, measure invulnerability window and pulse width
    rocket = 3'b001;
    step();
    chk("hit lives", lives, 2);
    chk("hit pulse", lifeLostPulse, 1);
    chk("hit invuln", invulnerable, 1);
    invCnt = 1; pulseCnt = 1;
    rocket = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (invulnerable) invCnt++;
      if (lifeLostPulse) pulseCnt++;
    end
    chk("invuln cycles", invCnt, 4);
    chk("pulse cycles", pulseCnt, 1);

    // two simultaneous rising edges count once; re-hit while invulnerable ignored
    doNewGame();
    chk("newgame lives", lives, 3);
    rocket = 3'b101;
    step();
    chk("dual-edge lives", lives, 2);
    rocket = 3'b000;
    step();
    rocket = 3'b010;
    step();
    chk("invuln hit lives", lives, 2);
    chk("invuln still", invulnerable, 1);
    rocket = 3'b000;
    step(5);
    chk("invuln over", invulnerable, 0);

    // drop to one life, then fatal alien collision
    rocket = 3'b001;
    step();
    chk("second hit lives", lives, 1);
    rocket = 3'b000;
    step(5);
    alienPulse = 1'b1;
    step();
    alienPulse = 1'b0;
    chk("fatal lives", lives, 0);
    chk("fatal lost", lost, 1);
    chk("fatal no pulse", lifeLostPulse, 0);
    step();
    chk("lost sticky", lost, 1);
    extra = 1'b1;
    step();
    extra = 1'b0;
    chk("dead extra lives", lives, 0);
    doNewGame();
    chk("restart lives", lives, 3);
    chk("restart lost", lost, 0);

    // god mode blocks damage but not the border
    god = 1'b1;
    rocket = 3'b001; step();
    rocket = 3'b000; step();
    rocket = 3'b100; step();
    rocket = 3'b000; alienPulse = 1'b1; step();
    alienPulse = 1'b0;
    chk("god lives", lives, 3);
    chk("god lost", lost, 0);
    chk("god invuln", invulnerable, 0);
    border = 1'b1;
    step();
    chk("border lost", lost, 1);
    chk("border lives", lives, 3);
    border = 1'b0; god = 1'b0;
    doNewGame();

    // saturation at MAX_LIVES
    extra = 1'b1;
    step(4);
    chk("extra to max", lives, 7);
    step();
    extra = 1'b0;
    chk("extra saturate", lives, 7);
    doNewGame();

    // damage and extra life in the same cycle: net zero, still invulnerable
    rocket = 3'b010; extra = 1'b1;
    step();
    rocket = 3'b000; extra = 1'b0;
    chk("net0 lives", lives, 3);
    chk("net0 invuln", invulnerable, 1);
    chk("net0 pulse", lifeLostPulse, 1);
    step(5);

    // rocket already overlapping across reset release is not a hit
    resetN = 1'b0; rocket = 3'b001;
    step();
    resetN = 1'b1;
    step();
    chk("held lives", lives, 3);
    chk("held pulse", lifeLostPulse, 0);
    rocket = 3'b000;
    step();
    rocket = 3'b001;
    step();
    chk("pre-reset lives", lives, 2);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    chk("mid-invuln reset lives", lives, 3);
    chk("mid-invuln reset invuln", invulnerable, 0);
    chk("mid-invuln reset lost", lost, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

`default_nettype wire
